// File: rtl/switch_debounce.sv
// Switch conditioning: per-bit synchroniser, tick-paced debounce, clean levels plus
// registered rise/fall/any-change pulses.
module switch_debounce #(
  parameter int unsigned WIDTH           = 8,
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned PRESCALE        = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] switches_raw,
  output logic [WIDTH-1:0] switches,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall,
  output logic             changed
);

  localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int unsigned CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [PW-1:0] PS_LAST = PW'(PRESCALE - 1);
  localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES - 1);

  // Elaboration-time parameter sanity checks
  if (WIDTH < 1) begin : g_chk_width
    $fatal(1, "switch_debounce: WIDTH must be > 0");
  end
  if (SYNC_STAGES < 2) begin : g_chk_sync
    $fatal(1, "switch_debounce: SYNC_STAGES must be >= 2");
  end
  if (DEBOUNCE_CYCLES < 1) begin : g_chk_db
    $fatal(1, "switch_debounce: DEBOUNCE_CYCLES must be >= 1");
  end
  if (PRESCALE < 1) begin : g_chk_ps
    $fatal(1, "switch_debounce: PRESCALE must be >= 1");
  end

  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
  logic [WIDTH-1:0]                  sync;
  logic [PW-1:0]                     pcnt_q, pcnt_d;
  logic                              tick;
  logic [WIDTH-1:0][CW-1:0]          cnt_q, cnt_d;
  logic [WIDTH-1:0]                  sw_d, rise_d, fall_d;
  logic                              changed_d;

  // Plain shift chain; newest sample enters stage 0
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], switches_raw};
    end
  end

  assign sync = sync_q[SYNC_STAGES-1];

  // Prescaler: tick in the cycle the counter sits at its terminal value
  assign tick   = (pcnt_q == PS_LAST);
  assign pcnt_d = tick ? '0 : pcnt_q + PW'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      pcnt_q <= '0;
    end else begin
      pcnt_q <= pcnt_d;
    end
  end

  // Per-bit stability counters; a matching sample always restarts the count
  always_comb begin
    cnt_d = cnt_q;
    sw_d  = switches;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (sync[i] == switches[i]) begin
        cnt_d[i] = '0;
      end else if (tick) begin
        if (cnt_q[i] == DB_LAST) begin
          sw_d[i]  = sync[i];
          cnt_d[i] = '0;
        end else begin
          cnt_d[i] = cnt_q[i] + CW'(1);
        end
      end
    end
    rise_d    = sw_d & ~switches;
    fall_d    = ~sw_d & switches;
    changed_d = |(rise_d | fall_d);
  end

  // Outputs and pulses update together so pulses line up with the new level
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q    <= '0;
      switches <= '0;
      rise     <= '0;
      fall     <= '0;
      changed  <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      switches <= sw_d;
      rise     <= rise_d;
      fall     <= fall_d;
      changed  <= changed_d;
    end
  end

endmodule

// File: tb/tb_switch_debounce.sv
// Bench for switch_debounce: default build plus a PRESCALE=4/DEBOUNCE_CYCLES=2 build,
// checked every cycle against a history-based reference model plus directed checks.
module tb_switch_debounce;

  localparam int unsigned W  = 8;
  localparam int          SS = 2;
  localparam int          HN = 8192;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] raw_a, raw_b;
  logic [W-1:0] sw_a, rise_a, fall_a, sw_b, rise_b, fall_b;
  logic         chg_a, chg_b;

  always #5 clk = ~clk;

  switch_debounce #(.WIDTH(W), .SYNC_STAGES(SS), .DEBOUNCE_CYCLES(4), .PRESCALE(1)) dut_a (
    .clk(clk), .rst(rst), .switches_raw(raw_a),
    .switches(sw_a), .rise(rise_a), .fall(fall_a), .changed(chg_a)
  );

  switch_debounce #(.WIDTH(W), .SYNC_STAGES(SS), .DEBOUNCE_CYCLES(2), .PRESCALE(4)) dut_b (
    .clk(clk), .rst(rst), .switches_raw(raw_b),
    .switches(sw_b), .rise(rise_b), .fall(fall_b), .changed(chg_b)
  );

  int           checks = 0;
  int           errors = 0;
  int           ecnt = 0;
  int           last_rst = 0;
  logic [W-1:0] raw_h [2][HN];
  int           last_acc [2][W];
  logic [W-1:0] msw [2];
  logic [W-1:0] mrise [2];
  logic [W-1:0] mfall [2];
  logic         mchg [2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: the synchronised level at edge k is the raw level sampled SS edges
  // earlier (0 if a reset intervened); a bit flips when the disagreement with the
  // output has lasted, unbroken since its last flip/reset, over exactly dc ticks.
  task automatic model_step(input int d, input logic [W-1:0] raw);
    int           dc, ps, cnt, k;
    logic [W-1:0] nsw, hv;
    logic         sb;
    dc = (d == 0) ? 4 : 2;
    ps = (d == 0) ? 1 : 4;
    k  = ecnt;
    if (rst) begin
      msw[d] = '0; mrise[d] = '0; mfall[d] = '0; mchg[d] = 1'b0;
      for (int i = 0; i < int'(W); i++) last_acc[d][i] = k;
      return;
    end
    raw_h[d][k] = raw;
    nsw = msw[d];
    if ((k - last_rst) % ps == 0) begin
      for (int i = 0; i < int'(W); i++) begin
        cnt = 0;
        for (int kk = k; kk > last_acc[d][i]; kk--) begin
          if (kk - SS > last_rst) begin
            hv = raw_h[d][kk-SS];
            sb = hv[i];
          end else begin
            sb = 1'b0;
          end
          if (sb == msw[d][i]) break;
          if ((kk - last_rst) % ps == 0) cnt++;
        end
        if (cnt == dc) begin
          nsw[i] = ~msw[d][i];
          last_acc[d][i] = k;
        end
      end
    end
    mrise[d] = nsw & ~msw[d];
    mfall[d] = ~nsw & msw[d];
    mchg[d]  = |(mrise[d] | mfall[d]);
    msw[d]   = nsw;
  endtask

  // One clock edge: advance the model, then compare both instances after the edge
  task automatic cyc();
    ecnt++;
    if (rst) last_rst = ecnt;
    model_step(0, raw_a);
    model_step(1, raw_b);
    @(posedge clk);
    #1;
    chk("a.switches", 32'(sw_a),   32'(msw[0]));
    chk("a.rise",     32'(rise_a), 32'(mrise[0]));
    chk("a.fall",     32'(fall_a), 32'(mfall[0]));
    chk("a.changed",  32'(chg_a),  32'(mchg[0]));
    chk("b.switches", 32'(sw_b),   32'(msw[1]));
    chk("b.rise",     32'(rise_b), 32'(mrise[1]));
    chk("b.fall",     32'(fall_b), 32'(mfall[1]));
    chk("b.changed",  32'(chg_b),  32'(mchg[1]));
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  initial begin
    int  seen, first_e, second_e, npulse, hold;
    bit  found;

    for (int d = 0; d < 2; d++) begin
      msw[d] = '0; mrise[d] = '0; mfall[d] = '0; mchg[d] = 1'b0;
      for (int i = 0; i < int'(W); i++) last_acc[d][i] = 0;
    end
    rst = 1'b1; raw_a = '0; raw_b = '0;

    // Test 1: reset, then step to 8'h21
    run(3);
    chk("t1.reset_switches", 32'(sw_a), 32'h00);
    chk("t1.reset_changed",  32'(chg_a), 32'h0);
    rst = 1'b0;
    raw_a = 8'h21;
    for (int i = 1; i <= 5; i++) begin
      cyc();
      chk("t1.not_yet", 32'(sw_a), 32'h00);
    end
    cyc();
    chk("t1.switches_e6", 32'(sw_a),   32'h21);
    chk("t1.rise_e6",     32'(rise_a), 32'h21);
    chk("t1.fall_e6",     32'(fall_a), 32'h00);
    chk("t1.changed_e6",  32'(chg_a),  32'h1);
    cyc();
    chk("t1.rise_drop",    32'(rise_a), 32'h00);
    chk("t1.changed_drop", 32'(chg_a),  32'h0);

    // Test 3: release bit 0
    raw_a = 8'h20;
    run(5);
    chk("t3.not_yet", 32'(sw_a), 32'h21);
    cyc();
    chk("t3.switches_e6", 32'(sw_a),   32'h20);
    chk("t3.fall_e6",     32'(fall_a), 32'h01);
    chk("t3.changed_e6",  32'(chg_a),  32'h1);
    cyc();
    chk("t3.fall_drop", 32'(fall_a), 32'h00);

    // Test 2: three-cycle glitch on bit 3 from all-zero
    raw_a = 8'h00;
    run(10);
    raw_a = 8'h08;
    seen = 0;
    for (int i = 0; i < 15; i++) begin
      if (i == 3) raw_a = 8'h00;
      cyc();
      if (chg_a || (rise_a != 0) || (fall_a != 0) || (sw_a != 0)) seen++;
    end
    chk("t2.glitch_activity", 32'(seen), 32'd0);

    // Test 4a: all bits at once -> one changed pulse
    raw_a = 8'hFF;
    npulse = 0;
    for (int i = 0; i < 10; i++) begin
      cyc();
      if (chg_a) begin
        npulse++;
        chk("t4.rise_all", 32'(rise_a), 32'hFF);
      end
    end
    chk("t4.single_pulse", 32'(npulse), 32'd1);
    raw_a = 8'h00;
    run(10);

    // Test 4b: bit 0 then bit 7 two cycles later
    raw_a = 8'h01;
    run(2);
    raw_a = 8'h81;
    npulse = 0; first_e = 0; second_e = 0;
    for (int i = 0; i < 12; i++) begin
      cyc();
      if (chg_a) begin
        npulse++;
        if (npulse == 1) first_e = ecnt; else second_e = ecnt;
      end
    end
    chk("t4.two_pulses", 32'(npulse), 32'd2);
    chk("t4.pulse_gap",  32'(second_e - first_e), 32'd2);
    raw_a = 8'h00;
    run(10);

    // Test 5: reset mid-count on bit 7
    raw_a = 8'h80;
    run(3);
    rst = 1'b1;
    cyc();
    chk("t5.rst_switches", 32'(sw_a),  32'h00);
    chk("t5.rst_rise",     32'(rise_a), 32'h00);
    chk("t5.rst_changed",  32'(chg_a), 32'h0);
    rst = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      cyc();
      chk("t5.no_rise_yet", 32'(rise_a), 32'h00);
    end
    cyc();
    chk("t5.rise7_e6", 32'(rise_a), 32'h80);

    // Test 6: prescaled build, rise on bit 0 within 10 edges
    raw_b = 8'h01;
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      cyc();
      if (sw_b[0]) found = 1'b1;
    end
    chk("t6.rise_within_10", 32'(found), 32'h1);
    run(4);
    // Align a 5-cycle glitch on bit 1 so its mismatch window holds only one tick
    for (int i = 0; i < 4 && ((ecnt + 1 - last_rst) % 4 != 3); i++) cyc();
    raw_b = 8'h03;
    seen = 0;
    for (int i = 0; i < 16; i++) begin
      if (i == 5) raw_b = 8'h01;
      cyc();
      if (chg_b || sw_b[1]) seen++;
    end
    chk("t6.glitch_rejected", 32'(seen), 32'd0);
    chk("t6.bit0_held", 32'(sw_b), 32'h01);

    // Randomised phase: random levels held for random spans, rare resets
    for (int seg = 0; seg < 160; seg++) begin
      if ($urandom_range(0, 2) == 0) raw_a = raw_a ^ (8'h01 << $urandom_range(0, 7));
      else                           raw_a = 8'($urandom);
      if ($urandom_range(0, 1) == 0) raw_b = raw_b ^ (8'h01 << $urandom_range(0, 7));
      else                           raw_b = 8'($urandom);
      if ($urandom_range(0, 40) == 0) begin
        rst = 1'b1;
        cyc();
        rst = 1'b0;
      end
      hold = $urandom_range(1, 14);
      run(hold);
    end
    raw_a = '0; raw_b = '0;
    run(20);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/switch_debounce.md
Name: switch_debounce

Overview:
- Upstream conditioning stage for the board switches, feeding the LED rotate stage.
- Synchronises each raw asynchronous switch bit into clk and debounces it with a per-bit stability counter.
- Presents a clean WIDTH-bit switch vector plus per-bit rise/fall pulses and a single any-change pulse.
- The downstream rotate stage consumes only `switches`. The pulses are for future logging and interrupt logic.

Parameters:
- WIDTH, 8, number of switch bits; must be >0.
- SYNC_STAGES, 2, flops in each synchroniser chain; must be >=2.
- DEBOUNCE_CYCLES, 4, consecutive ticks a new level must persist before acceptance; must be >=1.
- PRESCALE, 1, clk cycles per debounce tick; must be >=1 (1 = tick every cycle).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- switches_raw  in  WIDTH  raw asynchronous switch levels.
- switches  out  WIDTH  debounced levels; feeds the rotate stage.
- rise  out  WIDTH  one-cycle pulse per bit on an accepted 0->1.
- fall  out  WIDTH  one-cycle pulse per bit on an accepted 1->0.
- changed  out  1  one-cycle pulse when any bit of `switches` updates.

Behaviour:
- Clocking and reset:
  - Single clock domain is clk.
  - rst is synchronous and active-high, sampled on the rising edge of clk.
- Reset values (all registers, applied on the edge where rst=1):
  - Synchroniser flops = 0.
  - Debounce counters = 0.
  - Prescaler = 0.
  - switches = 0, rise = 0, fall = 0, changed = 0.
- Parameter checks: elaboration-time check of all parameter minimums; $fatal on violation.
- Synchroniser:
  - Per-bit shift chain of SYNC_STAGES flops.
  - sync[i] is the last flop of the chain.
  - No logic between chain flops.
- Prescaler:
  - Counter 0..PRESCALE-1, wraps to 0.
  - tick=1 in the cycle the counter equals PRESCALE-1.
  - PRESCALE=1 gives tick=1 every cycle.
  - Counter width is max(1, clog2(PRESCALE)).
- Per-bit debounce (counter cnt[i], width max(1, clog2(DEBOUNCE_CYCLES))), evaluated each edge:
  - If sync[i]==switches[i]: cnt[i] <= 0, regardless of tick.
  - Else if tick and cnt[i]==DEBOUNCE_CYCLES-1: switches[i] <= sync[i] and cnt[i] <= 0.
  - Else if tick: cnt[i] <= cnt[i]+1.
  - Else: hold.
- Glitch rejection:
  - A mismatch that disappears before DEBOUNCE_CYCLES ticks clears the counter.
  - No output change results.
- Latency (PRESCALE=1), counted from the first clk edge sampling the new raw level:
  - sync[i] updates on edge SYNC_STAGES.
  - switches[i] updates on edge SYNC_STAGES+DEBOUNCE_CYCLES.
  - Defaults give 6 edges.
- Pulses:
  - rise[i], fall[i] and changed are registered and assert in the same cycle `switches` takes its new value.
  - Each deasserts on the next edge unless another bit flips.
  - changed = OR of the next-state rise|fall.
  - Several bits accepted on the same edge give one changed pulse with multiple rise/fall bits set.
- Bit independence: bits are fully independent; no cross-bit arbitration.
- Reset mid-operation:
  - Partial counts are discarded and outputs are forced to 0; no pulses are emitted on the reset edge.
  - After release, a raw bit held at 1 produces rise after SYNC_STAGES+DEBOUNCE_CYCLES edges, counted from the first non-reset edge.
- Counter bounds: counters saturate logically by clearing at DEBOUNCE_CYCLES-1 and never wrap through an undefined value.

Test Plan:
1. Reset then step: rst 3 cycles; after release, switches_raw=8'h00->8'h21 and held.
   - Required: switches=8'h21 exactly 6 edges after the first sampling edge.
   - Required: rise=8'h21 and changed=1 for one cycle; fall=0.
2. Glitch rejection: from switches=8'h00, pulse bit 3 high for 3 cycles, then low.
   - Required: switches stays 8'h00; rise, fall and changed never assert.
3. Release: from switches=8'h21, set raw=8'h20.
   - Required: after 6 edges, switches=8'h20, fall=8'h01 for one cycle, changed=1 for one cycle.
4. Simultaneous and staggered:
   - Raw 8'h00->8'hFF on one edge: a single changed pulse with rise=8'hFF.
   - Bit 0 and bit 7 raised 2 cycles apart: two separate changed pulses, 2 cycles apart.
5. Reset mid-count: raw=8'h80; assert rst on edge 4 (count in progress) for 1 cycle, raw still 8'h80.
   - Required: switches=0 with no pulse during reset.
   - Required: rise[7] exactly 6 edges after reset release.
6. Prescale: rebuild with PRESCALE=4, DEBOUNCE_CYCLES=2; raw 0->1 on bit 0.
   - Required: switches[0] rises after 2 sync edges plus 2 ticks, within 2+8 edges.
   - Required: a 5-cycle glitch aligned to miss a second tick is rejected.
